// File: rtl/v_reserve_tracker_if.sv
// Scheduler <-> reservation tracker bus: start pulses with issue parameters in,
// registered busy/chain status out.
interface v_reserve_tracker_if #(
  parameter int LOGDEPTH = 6
);
  logic [7:0]        i_vwrite_start;
  logic [7:0]        i_vread_start;
  logic [7:0]        i_vfu_start;
  logic [3:0]        i_fu_delay;
  logic [LOGDEPTH:0] i_vl;
  logic [7:0]        o_vreg_busy;
  logic [7:0]        o_vreg_chain_n;
  logic [7:0]        o_vfu_busy;

  modport master (
    output i_vwrite_start, i_vread_start, i_vfu_start, i_fu_delay, i_vl,
    input  o_vreg_busy, o_vreg_chain_n, o_vfu_busy
  );
  modport slave (
    input  i_vwrite_start, i_vread_start, i_vfu_start, i_fu_delay, i_vl,
    output o_vreg_busy, o_vreg_chain_n, o_vfu_busy
  );
endinterface

// File: rtl/v_reserve_tracker.sv
// Vector register / FU reservation tracker: turns scheduler start pulses into
// per-register busy and chain-window status and per-FU busy status.

// Down-counter reservation: loads the length on start, busy while nonzero.
module v_rt_cnt #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] len,
  output logic         busy
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (start)       cnt <= len;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign busy = (cnt != '0);
endmodule

// Per-register write reservation FSM: FU latency, then a short chain window,
// then streaming until the last element has been written.
module v_rt_wfsm #(
  parameter int LOGDEPTH  = 6,
  parameter int CHAIN_WIN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        delay,
  input  logic [LOGDEPTH:0] len,
  output logic              active,
  output logic              chain
);
  localparam int CCW = (CHAIN_WIN > 1) ? $clog2(CHAIN_WIN) : 1;
  localparam logic [CCW-1:0] CC_INIT = CCW'(CHAIN_WIN - 1);

  typedef enum logic [1:0] {IDLE, DELAY, CHAIN, STREAM} wstate_e;

  wstate_e           state, state_nxt;
  logic [LOGDEPTH:0] ecnt, ecnt_nxt;
  logic [3:0]        dcnt, dcnt_nxt;
  logic [CCW-1:0]    ccnt, ccnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ecnt  <= '0;
      dcnt  <= '0;
      ccnt  <= '0;
    end else begin
      state <= state_nxt;
      ecnt  <= ecnt_nxt;
      dcnt  <= dcnt_nxt;
      ccnt  <= ccnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ecnt_nxt  = ecnt;
    dcnt_nxt  = dcnt;
    ccnt_nxt  = ccnt;
    case (state)
      DELAY: begin
        if (dcnt == 4'd0) begin
          state_nxt = CHAIN;
          ccnt_nxt  = CC_INIT;
        end else begin
          dcnt_nxt = dcnt - 4'd1;
        end
      end
      CHAIN: begin
        ecnt_nxt = ecnt - 1'b1;
        // Last element wins over the window expiring.
        if (ecnt == 1)          state_nxt = IDLE;
        else if (ccnt == '0)    state_nxt = STREAM;
        else                    ccnt_nxt  = ccnt - 1'b1;
      end
      STREAM: begin
        ecnt_nxt = ecnt - 1'b1;
        if (ecnt == 1) state_nxt = IDLE;
      end
      default: ;
    endcase
    // A new start discards whatever reservation was in flight.
    if (start) begin
      ecnt_nxt = len;
      if (delay != 4'd0) begin
        state_nxt = DELAY;
        dcnt_nxt  = delay - 4'd1;
      end else begin
        state_nxt = CHAIN;
        ccnt_nxt  = CC_INIT;
      end
    end
  end

  always_comb begin
    active = (state != IDLE);
    chain  = (state == CHAIN);
  end
endmodule

module v_reserve_tracker #(
  parameter int LOGDEPTH  = 6,
  parameter int CHAIN_WIN = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  v_reserve_tracker_if.slave bus
);
  logic [LOGDEPTH:0] len;
  logic [7:0]        wr_act, wr_chain, rd_busy, fu_busy;

  // A zero length encodes a full-depth vector.
  assign len = (bus.i_vl == '0) ? {1'b1, {LOGDEPTH{1'b0}}} : bus.i_vl;

  for (genvar g = 0; g < 8; g++) begin : g_lane
    v_rt_wfsm #(.LOGDEPTH(LOGDEPTH), .CHAIN_WIN(CHAIN_WIN)) u_wr (
      .clk   (clk),
      .rst_n (rst_n),
      .start (bus.i_vwrite_start[g]),
      .delay (bus.i_fu_delay),
      .len   (len),
      .active(wr_act[g]),
      .chain (wr_chain[g])
    );
    v_rt_cnt #(.W(LOGDEPTH + 1)) u_rd (
      .clk  (clk),
      .rst_n(rst_n),
      .start(bus.i_vread_start[g]),
      .len  (len),
      .busy (rd_busy[g])
    );
    v_rt_cnt #(.W(LOGDEPTH + 1)) u_fu (
      .clk  (clk),
      .rst_n(rst_n),
      .start(bus.i_vfu_start[g]),
      .len  (len),
      .busy (fu_busy[g])
    );
  end

  // Status is decoded purely from flops, so no input reaches an output
  // in the same cycle.
  assign bus.o_vreg_busy    = wr_act | rd_busy;
  assign bus.o_vreg_chain_n = ~(wr_chain & ~rd_busy);
  assign bus.o_vfu_busy     = fu_busy;
endmodule

// File: doc/v_reserve_tracker.md
V_RESERVE_TRACKER -- requirements
Module: v_reserve_tracker

Interface
REQ-001 Parameter LOGDEPTH, default 6, log2 of the vector register depth.
REQ-002 Parameter CHAIN_WIN, default 1, number of cycles a write-reserved register is chainable.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_vwrite_start  input  8  one-hot per V register: a write reservation starts this cycle.
REQ-006 i_vread_start  input  8  per V register: a read reservation starts this cycle; may be two-hot, for Vj and Vk.
REQ-007 i_vfu_start  input  8  one-hot per vector FU: the FU is reserved this cycle (bit order VLOG, VSHIFT, VADD, FP_MUL, FP_ADD, FP_RA, VPOP, MEM).
REQ-008 i_fu_delay  input  4  FU latency in cycles for the issuing instruction; sampled with any start bit.
REQ-009 i_vl  input  LOGDEPTH+1  vector length; sampled with any start bit.
REQ-010 o_vreg_busy  output  8  per register: the register is reserved.
REQ-011 o_vreg_chain_n  output  8  per register, active-low: 0 means the register is chainable as a Vj/Vk source.
REQ-012 o_vfu_busy  output  8  per FU: the FU is reserved.

Function
REQ-013 The block is the responder to the vector scheduler: it converts its start pulses into busy/chain status fed back to issue.
REQ-014 All outputs are registered, with no combinational path from any input to any output.
REQ-015 i_vl==0 is treated as 2^LOGDEPTH elements; the effective length is n = 1..2^LOGDEPTH.
REQ-016 Each register has a write FSM with states IDLE, DELAY, CHAIN and STREAM, plus an element counter of LOGDEPTH+1 bits and a delay counter of 4 bits.
REQ-017 Write start sampled at edge t: if i_fu_delay>0, go to DELAY with the delay counter set to i_fu_delay-1; otherwise go to CHAIN; the element counter loads n.
REQ-018 DELAY: the delay counter decrements each cycle; on an edge where it is 0, go to CHAIN.
REQ-019 CHAIN and STREAM: the element counter decrements once per cycle.
REQ-020 CHAIN lasts min(CHAIN_WIN, n) cycles, then goes to STREAM.
REQ-021 On an edge where the element counter is 1 (in CHAIN or STREAM), go to IDLE.
REQ-022 As a result, write busy is asserted for cycles t+1 .. t+i_fu_delay+n.
REQ-023 Each register has a read counter that loads n on a read start; read busy is asserted for cycles t+1 .. t+n.
REQ-024 o_vreg_busy[r] = write FSM not IDLE OR read counter nonzero.
REQ-025 o_vreg_chain_n[r] = 0 only while the write FSM is in CHAIN and the read counter is 0; it is 1 otherwise, including when idle.
REQ-026 Each FU has a counter that loads n on an i_vfu_start bit; o_vfu_busy is asserted for cycles t+1 .. t+n.
REQ-027 Simultaneous write start and read start on the same register: both reservations run independently; busy is the OR of the two.
REQ-028 A start on an already-reserved register or FU restarts that FSM or counter with the new values; the old reservation is discarded.
REQ-029 A start on the cycle a reservation ends takes effect, so busy stays asserted continuously.
REQ-030 Start bits arriving while the corresponding busy is asserted are legal and are handled per REQ-028.
REQ-031 All 8 registers and 8 FUs operate independently and concurrently.
REQ-032 Implementation budget: 120-400 lines of RTL.

Reset
REQ-033 While rst_n=0, and immediately on its assertion: all FSMs are IDLE and all counters are 0.
REQ-034 Reset output values: o_vreg_busy=8'h00, o_vfu_busy=8'h00, o_vreg_chain_n=8'hFF.
REQ-035 Reset asserted mid-operation aborts every reservation.
REQ-036 The first start is accepted on the first rising edge after rst_n deasserts.

Verification
REQ-037 Write V3, fu_delay=3, vl=4, start at cycle 0 -> o_vreg_busy[3] high for cycles 1-7; o_vreg_chain_n[3]=0 only in cycle 4; returns to 0/1 in cycle 8.
REQ-038 Write V0, fu_delay=0, vl=1 -> busy[0] and chain_n[0]=0 in cycle 1 only; both idle in cycle 2.
REQ-039 Read V5 + V6 and FU bit 2, vl=0 -> busy[5], busy[6] and o_vfu_busy[2] high for cycles 1-64 exactly.
REQ-040 Write V2 (delay 2, vl 8) plus read V2 (vl 8) in the same cycle -> busy[2] cycles 1-10; chain_n[2] stays 1 throughout, because the read is active during CHAIN.
REQ-041 Restart: write V1 (delay 5, vl 10), then a new write V1 (delay 1, vl 2) in cycle 3 -> busy[1] ends after cycle 6; chain_n[1]=0 in cycle 5.
REQ-042 Reset pulse in cycle 4 of scenario REQ-037 -> all busy 0 and chain_n=FF asynchronously; no activity until the next start.
